// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping address range out of a 1-cycle-latency BRAM as a valid/ready stream.
// Optional macro BRAM_STREAM_PARITY_EN adds an m_parity output carried with each beat.
module bram_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef BRAM_STREAM_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   rem_reg;
    logic              inflight_reg;
    logic              inflight_last_reg;
    logic [DATA_W-1:0] fifo_data_reg [2];
    logic              fifo_last_reg [2];
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic [1:0]        count_reg;
`ifdef BRAM_STREAM_PARITY_EN
    logic              fifo_par_reg [2];
`endif

    logic       pop;
    logic       push;
    logic       issue;
    logic       last_issue;
    logic [2:0] pending;

    assign pop        = m_valid && m_ready;
    assign push       = inflight_reg;
    assign pending    = {1'b0, count_reg} + {2'b00, inflight_reg};
    // Allow a new read only if the skid FIFO can still absorb it after this cycle's pop.
    assign issue      = (state_reg == READ) && (pending < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (rem_reg == {{ADDR_W{1'b0}}, 1'b1});

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign bram_ena  = issue;
    assign bram_wea  = 1'b0;
    assign bram_addr = addr_reg;
    assign bram_din  = '0;
    assign m_valid   = (count_reg != 2'd0);
    assign m_data    = fifo_data_reg[rd_ptr_reg];
    assign m_last    = fifo_last_reg[rd_ptr_reg];
`ifdef BRAM_STREAM_PARITY_EN
    assign m_parity  = fifo_par_reg[rd_ptr_reg];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            rem_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            rd_ptr_reg        <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            count_reg         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
`ifdef BRAM_STREAM_PARITY_EN
                fifo_par_reg[i]  <= 1'b0;
`endif
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg  <= base_addr;
                        rem_reg   <= length;
                        state_reg <= (length == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_reg <= addr_reg + 1'b1;
                        rem_reg  <= rem_reg - 1'b1;
                        if (last_issue) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            inflight_reg      <= issue;
            inflight_last_reg <= last_issue;

            // Read data is valid the cycle after the issue; capture it then.
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= bram_dout;
                fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
`ifdef BRAM_STREAM_PARITY_EN
                fifo_par_reg[wr_ptr_reg]  <= ^bram_dout;
`endif
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized/directed bench for bram_stream_reader with a queue-based reference of the expected stream.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [5:0]  length = '0;
    logic        busy, done, bram_ena, bram_wea;
    logic [4:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
`ifdef BRAM_STREAM_PARITY_EN
    logic        m_parity;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [32];
    logic [31:0] exp_data [$];
    logic        exp_last [$];
    logic [4:0]  exp_addr [$];

    always #5 clk = ~clk;

    bram_stream_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .bram_ena(bram_ena), .bram_wea(bram_wea),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef BRAM_STREAM_PARITY_EN
        , .m_parity(m_parity)
`endif
    );

    // BRAM behavioural model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bram_ena && !bram_wea) bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a command is the list of words at (base+i) mod 32, last flag on the final one.
    task automatic model_cmd(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] a;
            a = 5'((int'(b) + i) % 32);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
            exp_last.push_back(i == n - 1);
        end
    endtask

    int          issues = 0;
    int          pops = 0;
    bit          stall_prev = 0;
    logic [31:0] held_data;
    logic        held_last;

    always @(negedge clk) begin
        if (rst) begin
            issues = 0;
            pops = 0;
            stall_prev = 0;
        end else begin
            if (bram_wea) chk("wea_high", bram_wea, 0);
            if (bram_ena) begin
                issues++;
                if (exp_addr.size() == 0) chk("unexpected_issue", 1, 0);
                else chk("bram_addr", bram_addr, exp_addr.pop_front());
            end
            if (m_valid) begin
                if (stall_prev) begin
                    chk("stall_data", m_data, held_data);
                    chk("stall_last", m_last, held_last);
                end
                if (m_ready) begin
                    pops++;
                    if (exp_data.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        logic [31:0] ed;
                        logic        el;
                        ed = exp_data.pop_front();
                        el = exp_last.pop_front();
                        $display("beat data=%08h last=%0b exp=%08h/%0b", m_data, m_last, ed, el);
                        chk("m_data", m_data, ed);
                        chk("m_last", m_last, el);
`ifdef BRAM_STREAM_PARITY_EN
                        chk("m_parity", m_parity, ^ed);
`endif
                    end
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    held_data = m_data;
                    held_last = m_last;
                end
            end else begin
                stall_prev = 0;
            end
            if (issues - pops > 2) chk("outstanding", issues - pops, 2);
        end
    end

    function automatic logic ready_for(input int mode, input int cyc);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0: return 1'b1;
            1: return pat[cyc % 6];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Issues a command and follows it to the done pulse; caller is anywhere, returns at a negedge.
    task automatic run_cmd(input logic [4:0] b, input int n, input int mode, input bit second);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        model_cmd(b, n);
        start = 1'b1;
        base_addr = b;
        length = 6'(n);
        m_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 5'($urandom);
        length = 6'($urandom);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            m_ready = ready_for(mode, cyc + 1);
            start = (second && cyc == 2);
            @(negedge clk);
            if (!busy) chk("busy_during_cmd", busy, 1);
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (mode == 0) chk("done_cycle", cyc, (n == 0) ? 0 : n + 2);
        chk("queue_empty", exp_data.size(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        $display("cmd base=%0d len=%0d mode=%0d done_at=%0d", b, n, mode, cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_ena", bram_ena, 0);
        chk("rst_data", m_data, 0);
        rst = 1'b0;

        run_cmd(5'd0, 20, 0, 0);
        run_cmd(5'd30, 4, 0, 0);
        run_cmd(5'd3, 8, 1, 0);
        run_cmd(5'd7, 0, 0, 0);
        run_cmd(5'd12, 5, 0, 1);
        run_cmd(5'd9, 32, 0, 0);

        // Reset mid-command: everything clears at once and no done follows.
        @(posedge clk); #1;
        model_cmd(5'd4, 16);
        start = 1'b1; base_addr = 5'd4; length = 6'd16; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ena", bram_ena, 0);
        chk("arst_addr", bram_addr, 0);
        chk("arst_valid", m_valid, 0);
        chk("arst_data", m_data, 0);
        chk("arst_last", m_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy || m_valid) chk("post_rst_idle", {done, busy, m_valid}, 0);
        end
        run_cmd(5'd20, 2, 0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            run_cmd(5'($urandom), int'($urandom_range(1, 32)), 2, 0);
        end

        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        run_cmd(5'd0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
